// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port data memory.
//   p0_* / p1_* : request side (req, we, addr, wdata in; ack, rdata out)
//   err         : out-of-range flag, valid alongside either ack
//   mem_*       : memory side (read/write strobes, address, write data, read result)
// Modports:
//   slave  - the arbiter's view
//   master - the requester/memory environment's view
interface data_mem_arbiter_if;
    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_ack;
    logic [31:0] p0_rdata;

    logic        p1_req;
    logic        p1_we;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_ack;
    logic [31:0] p1_rdata;

    logic        err;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic [31:0] mem_result;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_result,
        output p0_ack, p0_rdata, p1_ack, p1_rdata, err,
        output mem_read, mem_write, mem_address, mem_data
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_result,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata, err,
        input  mem_read, mem_write, mem_address, mem_data
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port data memory.
// Each transaction runs Idle -> Access -> Done -> Idle: the winner's request is latched in Idle,
// the memory is strobed for exactly one Access cycle, and the winner's ack pulses in Done.
// Every output is registered.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-low reset
//   bus - data_mem_arbiter_if.slave (p0/p1 request ports, err, data memory port)
// Parameters:
//   BASE_ADDR - lowest valid byte address
//   MEM_BYTES - memory size in bytes
// Configuration:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous requests alternate between the ports.
//                        When undefined, port 0 has fixed priority.
module data_mem_arbiter #(
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned MEM_BYTES = 256
) (
    input logic                  clk,
    input logic                  rst,
    data_mem_arbiter_if.slave    bus
);

    localparam logic [31:0] LoAddr = 32'(BASE_ADDR);
    // Highest address at which a full word still fits in the memory
    localparam logic [31:0] HiAddr = 32'(BASE_ADDR + MEM_BYTES - 4);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q;
    logic        port_q;       // latched winner: 0 = port 0, 1 = port 1
    logic        oor_q;        // latched out-of-range flag
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_data_q;
    logic        p0_ack_q;
    logic        p1_ack_q;
    logic        err_q;
    logic [31:0] p0_rdata_q;
    logic [31:0] p1_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic        last_q;       // port granted most recently
`endif

    logic        any_req;
    logic        grant_p1;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_oor;

    always_comb begin
        any_req = bus.p0_req | bus.p1_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.p0_req && bus.p1_req) begin
            grant_p1 = ~last_q;
        end else begin
            grant_p1 = bus.p1_req;
        end
`else
        grant_p1 = ~bus.p0_req & bus.p1_req;
`endif
        sel_we    = grant_p1 ? bus.p1_we    : bus.p0_we;
        sel_addr  = grant_p1 ? bus.p1_addr  : bus.p0_addr;
        sel_wdata = grant_p1 ? bus.p1_wdata : bus.p0_wdata;
        sel_oor   = (sel_addr < LoAddr) || (sel_addr > HiAddr);
    end

    // The mem_* registers double as the latched request: they are loaded on entry to Access
    // and cleared on leaving it, so they read as 0 everywhere else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            port_q        <= 1'b0;
            oor_q         <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= 32'h0;
            mem_data_q    <= 32'h0;
            p0_ack_q      <= 1'b0;
            p1_ack_q      <= 1'b0;
            err_q         <= 1'b0;
            p0_rdata_q    <= 32'h0;
            p1_rdata_q    <= 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q        <= 1'b1;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        port_q        <= grant_p1;
                        oor_q         <= sel_oor;
                        mem_read_q    <= ~sel_oor & ~sel_we;
                        mem_write_q   <= ~sel_oor & sel_we;
                        mem_address_q <= sel_addr;
                        mem_data_q    <= sel_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                        last_q        <= grant_p1;
`endif
                        state_q       <= StAccess;
                    end
                end
                StAccess: begin
                    mem_read_q    <= 1'b0;
                    mem_write_q   <= 1'b0;
                    mem_address_q <= 32'h0;
                    mem_data_q    <= 32'h0;
                    // Only the winner's rdata moves; the other port keeps its last value
                    if (port_q) begin
                        p1_rdata_q <= oor_q ? 32'h0 : bus.mem_result;
                    end else begin
                        p0_rdata_q <= oor_q ? 32'h0 : bus.mem_result;
                    end
                    p0_ack_q <= ~port_q;
                    p1_ack_q <= port_q;
                    err_q    <= oor_q;
                    state_q  <= StDone;
                end
                StDone: begin
                    // No arbitration here; pending requests are seen in the next Idle
                    p0_ack_q <= 1'b0;
                    p1_ack_q <= 1'b0;
                    err_q    <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.p0_ack      = p0_ack_q;
    assign bus.p1_ack      = p1_ack_q;
    assign bus.p0_rdata    = p0_rdata_q;
    assign bus.p1_rdata    = p1_rdata_q;
    assign bus.err         = err_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural data memory and a scoreboard of
// expected acks (port, rdata, err, cycle of the ack).
module tb_data_mem_arbiter;

    localparam int unsigned BaseAddr = 1024;
    localparam int unsigned MemBytes = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_mem_arbiter_if bus ();

    data_mem_arbiter #(
        .BASE_ADDR (BaseAddr),
        .MEM_BYTES (MemBytes)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- behavioural data memory ----------------
    function automatic logic [31:0] init_word(input logic [5:0] idx);
        return 32'h1000_0000 + 32'(idx) * 32'h0001_0203;
    endfunction

    function automatic logic in_range(input logic [31:0] a);
        return (a >= 32'(BaseAddr)) && (a <= 32'(BaseAddr + MemBytes - 4));
    endfunction

    function automatic logic [5:0] word_idx(input logic [31:0] a);
        return 6'((a - 32'(BaseAddr)) >> 2);
    endfunction

    bit [31:0]  ram    [64];
    bit         ram_wr [64];
    logic [5:0] ram_idx;

    assign ram_idx = word_idx(bus.mem_address);

    always_comb begin
        bus.mem_result = 32'h0;
        if (in_range(bus.mem_address)) begin
            bus.mem_result = ram_wr[ram_idx] ? ram[ram_idx] : init_word(ram_idx);
        end
    end

    always @(posedge clk) begin
        if (bus.mem_write && in_range(bus.mem_address)) begin
            ram[ram_idx]    <= bus.mem_data;
            ram_wr[ram_idx] <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          port;
        logic [31:0] rdata;
        logic        err;
        bit          chk_rdata;
        int          cyc;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [64];
    int          n_pass  = 0;
    int          n_total = 0;
    int          n_rd;
    int          n_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic push(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int cyc);
        exp_t e;
        logic oor;
        oor = !in_range(addr);
        if (!oor && we) model[word_idx(addr)] = wdata;
        e.port      = port;
        e.err       = oor;
        e.rdata     = oor ? 32'h0 : model[word_idx(addr)];
        e.chk_rdata = oor || !we;
        e.cyc       = cyc;
        sb.push_back(e);
    endtask

    task automatic drive(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        if (port) begin
            bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end else begin
            bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end
    endtask

    // Runs ncyc clock cycles, observing at each falling edge; pops the scoreboard on every ack.
    // cyc+1 is the rising edge at which a requester samples the ack (sampling edge = 1).
    task automatic window(input int ncyc, input bit drop_early, input bit hold);
        exp_t e;
        n_rd = 0;
        n_wr = 0;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.mem_read && bus.mem_write) chk("strobe_exclusive", 32'd1, 32'd0);
            if (bus.mem_read)  n_rd++;
            if (bus.mem_write) n_wr++;
            if (drop_early && cyc == 1) begin
                bus.p0_req = 1'b0;
                bus.p1_req = 1'b0;
            end
            if (bus.p0_ack || bus.p1_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", 32'(bus.p1_ack), 32'(e.port));
                    chk("other_ack_low", 32'(e.port ? bus.p0_ack : bus.p1_ack), 32'd0);
                    chk("ack_cycle", 32'(cyc + 1), 32'(e.cyc));
                    chk("ack_err", 32'(bus.err), 32'(e.err));
                    if (e.chk_rdata) chk("ack_rdata", e.port ? bus.p1_rdata : bus.p0_rdata, e.rdata);
                    if (!hold) begin
                        if (e.port) bus.p1_req = 1'b0;
                        else        bus.p0_req = 1'b0;
                    end
                end
            end
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_read"},  32'(bus.mem_read),  32'd0);
        chk({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
        chk({tag, "_mem_addr"},  bus.mem_address,    32'd0);
        chk({tag, "_mem_data"},  bus.mem_data,       32'd0);
        chk({tag, "_p0_ack"},    32'(bus.p0_ack),    32'd0);
        chk({tag, "_p1_ack"},    32'(bus.p1_ack),    32'd0);
        chk({tag, "_err"},       32'(bus.err),       32'd0);
        chk({tag, "_p0_rdata"},  bus.p0_rdata,       32'd0);
        chk({tag, "_p1_rdata"},  bus.p1_rdata,       32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) model[i] = init_word(6'(i));
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = 32'h0; bus.p0_wdata = 32'h0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 32'h0; bus.p1_wdata = 32'h0;

        // Reset state
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Port 0 write then read
        drive(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF);
        push(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 3);
        window(3, 1'b0, 1'b0);
        chk("wr_mem_write_cycles", 32'(n_wr), 32'd1);
        chk("wr_mem_read_cycles",  32'(n_rd), 32'd0);

        drive(1'b0, 1'b0, 32'd1032, 32'h0);
        push(1'b0, 1'b0, 32'd1032, 32'h0, 3);
        window(3, 1'b0, 1'b0);
        chk("rd_mem_read_cycles",  32'(n_rd), 32'd1);
        chk("rd_mem_write_cycles", 32'(n_wr), 32'd0);

        // Range edges on port 1
        drive(1'b1, 1'b0, 32'd1023, 32'h0);
        push(1'b1, 1'b0, 32'd1023, 32'h0, 3);
        window(3, 1'b0, 1'b0);
        chk("low_oor_strobes", 32'(n_rd + n_wr), 32'd0);
        chk("p0_rdata_held", bus.p0_rdata, 32'hDEAD_BEEF);

        drive(1'b1, 1'b0, 32'd1276, 32'h0);
        push(1'b1, 1'b0, 32'd1276, 32'h0, 3);
        window(3, 1'b0, 1'b0);
        chk("top_word_read_cycles", 32'(n_rd), 32'd1);

        drive(1'b0, 1'b1, 32'd1280, 32'h5555_AAAA);
        push(1'b0, 1'b1, 32'd1280, 32'h5555_AAAA, 3);
        window(3, 1'b0, 1'b0);
        chk("high_oor_strobes", 32'(n_rd + n_wr), 32'd0);

        // Early drop: port 1 read, req released during Access
        drive(1'b1, 1'b1, 32'd1036, 32'h0BAD_CAFE);
        push(1'b1, 1'b1, 32'd1036, 32'h0BAD_CAFE, 3);
        window(3, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 32'd1036, 32'h0);
        push(1'b1, 1'b0, 32'd1036, 32'h0, 3);
        window(3, 1'b1, 1'b0);
        chk("early_drop_read_cycles", 32'(n_rd), 32'd1);

        // Contention from a fresh reset (last grant = port 1)
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd1024, 32'h0);
        drive(1'b1, 1'b0, 32'd1028, 32'h0);
`ifdef ARB_ROUND_ROBIN_EN
        push(1'b0, 1'b0, 32'd1024, 32'h0, 3);
        push(1'b1, 1'b0, 32'd1028, 32'h0, 6);
        push(1'b0, 1'b0, 32'd1024, 32'h0, 9);
`else
        push(1'b0, 1'b0, 32'd1024, 32'h0, 3);
        push(1'b0, 1'b0, 32'd1024, 32'h0, 6);
        push(1'b0, 1'b0, 32'd1024, 32'h0, 9);
`endif
        window(9, 1'b0, 1'b1);
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        window(3, 1'b0, 1'b0);
        chk("contention_quiet_reads", 32'(n_rd), 32'd0);

        // Reset during Access of a port 0 write
        drive(1'b0, 1'b1, 32'd1040, 32'hCAFE_F00D);
        @(posedge clk);
        @(negedge clk);
        chk("abort_in_access", 32'(bus.mem_write), 32'd1);
        rst = 1'b0;
        bus.p0_req = 1'b0;
        #1;
        check_all_zero("abort");
        window(3, 1'b0, 1'b0);
        rst = 1'b1;

        // FSM must be back in Idle: a fresh read completes with normal latency
        drive(1'b0, 1'b0, 32'd1044, 32'h0);
        push(1'b0, 1'b0, 32'd1044, 32'h0, 3);
        window(3, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
